// File: rtl/pipe_ctrl_fwd.sv
// Parametrised pipeline controller: per-stage valid bits, allow_in/fire handshake,
// cancel flush and operand bypass into ID. Define PIPE_PERF_CNT_EN to build the stall/flush counters.
module pipe_ctrl_fwd #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned DW     = 32,
  parameter int unsigned RW     = 5
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cancel,
  input  logic [STAGES-1:0]         stage_over,
  input  logic [RW-1:0]             rs,
  input  logic [RW-1:0]             rt,
  input  logic [DW-1:0]             rf_rs,
  input  logic [DW-1:0]             rf_rt,
  input  logic [STAGES-3:0]         p_wen,
  input  logic [(STAGES-2)*RW-1:0]  p_wdest,
  input  logic [(STAGES-2)*DW-1:0]  p_data,
  input  logic [STAGES-3:0]         p_rdy,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES-1:0]         allow_in,
  output logic [STAGES-2:0]         stage_fire,
  output logic                      id_hazard,
  output logic [DW-1:0]             rs_val,
  output logic [DW-1:0]             rt_val,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
);

  localparam int unsigned NP = STAGES - 2;

  logic [STAGES-1:0] over_eff;
  logic              rs_wait;
  logic              rt_wait;

  // Bypass: scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    rs_val  = rf_rs;
    rt_val  = rf_rt;
    rs_wait = 1'b0;
    rt_wait = 1'b0;
    for (int j = int'(NP) - 1; j >= 0; j--) begin
      if (stage_valid[j+2] && p_wen[j] && (rs != '0) && (p_wdest[j*RW +: RW] == rs)) begin
        rs_val  = p_data[j*DW +: DW];
        rs_wait = ~p_rdy[j];
      end
      if (stage_valid[j+2] && p_wen[j] && (rt != '0) && (p_wdest[j*RW +: RW] == rt)) begin
        rt_val  = p_data[j*DW +: DW];
        rt_wait = ~p_rdy[j];
      end
    end
  end

  assign id_hazard = stage_valid[1] & (rs_wait | rt_wait);

  // Handshake chain, resolved from the last stage back towards IF.
  always_comb begin
    over_eff    = stage_over & stage_valid;
    over_eff[1] = stage_over[1] & stage_valid[1] & ~id_hazard;
    allow_in    = '0;
    allow_in[STAGES-1] = ~stage_valid[STAGES-1] | over_eff[STAGES-1];
    for (int k = int'(STAGES) - 2; k >= 1; k--) begin
      allow_in[k] = ~stage_valid[k] | (over_eff[k] & allow_in[k+1]);
    end
    allow_in[0] = (over_eff[0] & allow_in[1]) | cancel;
    for (int k = 0; k < int'(STAGES) - 1; k++) begin
      stage_fire[k] = over_eff[k] & allow_in[k+1];
    end
  end

  // Valid bits: IF is always live out of reset; cancel empties every later stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= 1'b1;
      for (int k = 1; k < int'(STAGES); k++) begin
        if (cancel) begin
          stage_valid[k] <= 1'b0;
        end else if (allow_in[k]) begin
          stage_valid[k] <= stage_fire[k-1];
        end
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (id_hazard && !cancel) stall_cnt <= stall_cnt + 32'd1;
      if (cancel)               flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_fwd.sv
// Directed bench for pipe_ctrl_fwd (STAGES=5): vector table for bypass/handshake,
// hand sequences for fill, stall, cancel, backpressure and mid-run reset.
module tb_pipe_ctrl_fwd;

`ifdef PIPE_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        cancel;
  logic [4:0]  stage_over;
  logic [4:0]  rs, rt;
  logic [31:0] rf_rs, rf_rt;
  logic [2:0]  p_wen;
  logic [14:0] p_wdest;
  logic [95:0] p_data;
  logic [2:0]  p_rdy;
  logic [4:0]  stage_valid;
  logic [4:0]  allow_in;
  logic [3:0]  stage_fire;
  logic        id_hazard;
  logic [31:0] rs_val, rt_val;
  logic [31:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;

  pipe_ctrl_fwd #(.STAGES(5), .DW(32), .RW(5)) dut (
    .clk(clk), .resetn(resetn), .cancel(cancel), .stage_over(stage_over),
    .rs(rs), .rt(rt), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .p_wen(p_wen), .p_wdest(p_wdest), .p_data(p_data), .p_rdy(p_rdy),
    .stage_valid(stage_valid), .allow_in(allow_in), .stage_fire(stage_fire),
    .id_hazard(id_hazard), .rs_val(rs_val), .rt_val(rt_val),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  over;
    logic [4:0]  rs, rt;
    logic [2:0]  wen;
    logic [14:0] wdest;
    logic [95:0] data;
    logic [2:0]  rdy;
    logic [31:0] e_rs, e_rt;
    logic        e_haz;
    logic [4:0]  e_allow;
    logic [3:0]  e_fire;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_cnt();
    check("stall_cnt", stall_cnt, CNT_EN ? exp_stall : 32'd0);
    check("flush_cnt", flush_cnt, CNT_EN ? exp_flush : 32'd0);
  endtask

  initial begin
    vt[0] = '{5'b11111, 5'd8, 5'd3, 3'b011, {5'd0, 5'd8, 5'd8}, {32'h0, 32'h22, 32'h11}, 3'b111,
              32'h11, 32'hB0B0, 1'b0, 5'b11111, 4'b1111};
    vt[1] = '{5'b11111, 5'd8, 5'd8, 3'b110, {5'd8, 5'd8, 5'd0}, {32'h33, 32'h22, 32'h0}, 3'b111,
              32'h22, 32'h22, 1'b0, 5'b11111, 4'b1111};
    vt[2] = '{5'b11111, 5'd0, 5'd0, 3'b111, {5'd0, 5'd0, 5'd0}, {32'hFFFF, 32'hFFFF, 32'hFFFF}, 3'b000,
              32'hA0A0, 32'hB0B0, 1'b0, 5'b11111, 4'b1111};
    vt[3] = '{5'b01111, 5'd1, 5'd9, 3'b011, {5'd0, 5'd9, 5'd9}, {32'h0, 32'h55, 32'h44}, 3'b010,
              32'hA0A0, 32'h44, 1'b1, 5'b00000, 4'b0000};
    vt[4] = '{5'b11111, 5'd1, 5'd9, 3'b011, {5'd0, 5'd9, 5'd9}, {32'h0, 32'h55, 32'h44}, 3'b001,
              32'hA0A0, 32'h44, 1'b0, 5'b11111, 4'b1111};
    vt[5] = '{5'b01111, 5'd5, 5'd2, 3'b100, {5'd5, 5'd0, 5'd0}, {32'h66, 32'h0, 32'h0}, 3'b011,
              32'h66, 32'hB0B0, 1'b1, 5'b00000, 4'b0000};
    vt[6] = '{5'b11111, 5'd7, 5'd7, 3'b000, {5'd7, 5'd7, 5'd7}, {32'h1, 32'h2, 32'h3}, 3'b000,
              32'hA0A0, 32'hB0B0, 1'b0, 5'b11111, 4'b1111};
    vt[7] = '{5'b11111, 5'd4, 5'd6, 3'b111, {5'd6, 5'd4, 5'd6}, {32'hCC, 32'hBB, 32'hAA}, 3'b111,
              32'hBB, 32'hAA, 1'b0, 5'b11111, 4'b1111};

    resetn = 1'b0; cancel = 1'b0; stage_over = 5'b11111;
    rs = '0; rt = '0; rf_rs = 32'hA0A0; rf_rt = 32'hB0B0;
    p_wen = '0; p_wdest = '0; p_data = '0; p_rdy = '1;

    // Reset state and fill.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(stage_valid), 32'h0);
    check("reset_allow", 32'(allow_in), 32'b11110);
    check_cnt();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("fill_%0d", i), 32'(stage_valid), 32'((1 << (i + 1)) - 1));
    end

    // Table: each vector keeps the pipe full across its edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      stage_over = vt[i].over; rs = vt[i].rs; rt = vt[i].rt;
      p_wen = vt[i].wen; p_wdest = vt[i].wdest; p_data = vt[i].data; p_rdy = vt[i].rdy;
      #1;
      check($sformatf("v%0d_valid", i), 32'(stage_valid), 32'h1F);
      check($sformatf("v%0d_rs_val", i), rs_val, vt[i].e_rs);
      check($sformatf("v%0d_rt_val", i), rt_val, vt[i].e_rt);
      check($sformatf("v%0d_hazard", i), 32'(id_hazard), 32'(vt[i].e_haz));
      check($sformatf("v%0d_allow", i), 32'(allow_in), 32'(vt[i].e_allow));
      check($sformatf("v%0d_fire", i), 32'(stage_fire), 32'(vt[i].e_fire));
      check($sformatf("v%0d_stall", i), stall_cnt, CNT_EN ? exp_stall : 32'd0);
      if (vt[i].e_haz) exp_stall = exp_stall + 32'd1;
    end

    // Stall on unready EXE: ID holds, EXE bubble then drains.
    @(negedge clk);
    stage_over = 5'b11111; rs = '0; rt = 5'd9;
    p_wen = 3'b001; p_wdest = {5'd0, 5'd0, 5'd9}; p_data = {64'h0, 32'h77}; p_rdy = 3'b000;
    #1;
    check("stall_hazard", 32'(id_hazard), 32'h1);
    check("stall_allow", 32'(allow_in), 32'b11100);
    check("stall_fire", 32'(stage_fire), 32'b1100);
    check("stall_rt_val", rt_val, 32'h77);
    check_cnt();
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    check("stall_valid", 32'(stage_valid), 32'b11011);
    check("stall_clear", 32'(id_hazard), 32'h0);
    check_cnt();
    p_wen = '0;
    @(negedge clk);
    check("bubble_1", 32'(stage_valid), 32'b10111);
    @(negedge clk);
    check("bubble_2", 32'(stage_valid), 32'b01111);
    @(negedge clk);
    check("bubble_3", 32'(stage_valid), 32'b11111);

    // Cancel during a hazard with backpressure.
    stage_over = 5'b01111; rt = 5'd9; p_wen = 3'b001; p_rdy = 3'b000; cancel = 1'b1;
    #1;
    check("cancel_hazard", 32'(id_hazard), 32'h1);
    check("cancel_allow", 32'(allow_in), 32'b00001);
    exp_flush = exp_flush + 32'd1;
    @(negedge clk);
    check("cancel_valid", 32'(stage_valid), 32'b00001);
    check_cnt();
    cancel = 1'b0; p_wen = '0; stage_over = 5'b11111;
    #1;
    check("cancel_allow_after", 32'(allow_in), 32'b11111);

    // Refill, then backpressure from the last stage freezes everything.
    repeat (4) @(negedge clk);
    check("refill_valid", 32'(stage_valid), 32'b11111);
    stage_over = 5'b01111;
    #1;
    check("bp_allow", 32'(allow_in), 32'b00000);
    check("bp_fire", 32'(stage_fire), 32'b0000);
    repeat (2) @(negedge clk);
    check("bp_valid", 32'(stage_valid), 32'b11111);
    check_cnt();

    // Mid-operation reset.
    resetn = 1'b0;
    exp_stall = 32'd0; exp_flush = 32'd0;
    @(negedge clk);
    check("rst2_valid", 32'(stage_valid), 32'h0);
    check_cnt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
